// File: rtl/dpram_line_reader_pkg.sv
// Shared definitions for the line-buffer read master: sizing helper, latency
// legality check and the command FSM state encoding.
package dpram_line_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    // Number of bits needed to represent value (0 for value 0).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit rd_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/dpram_line_reader_if.sv
// Valid/ready output stream carrying line-buffer words to the pixel pipeline.
interface dpram_line_reader_if #(
    parameter int RAM_WIDTH = 64
);
    logic [RAM_WIDTH-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/line_rd_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; the head word
// reads as zero while empty so the stream bus is clean after reset.
module line_rd_fifo
    import dpram_line_reader_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int PW = clogb2(DEPTH - 1),
    localparam int CW = clogb2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_rd;

    assign valid   = (count != '0);
    assign do_rd   = rd_en && valid;
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dpram_line_reader.sv
// Read master for the line-buffer dual-port RAM: issues credit-limited reads,
// tracks the RAM read latency and streams the words out with tlast.
module dpram_line_reader
    import dpram_line_reader_pkg::*;
#(
    parameter int RAM_WIDTH  = 64,
    parameter int RAM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clka,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          length,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        addrb,
    output logic                 enb,
    output logic                 regceb,
    output logic                 rstb,
    input  logic [RAM_WIDTH-1:0] doutb,
    dpram_line_reader_if.master  strm
);

    localparam int CW = clogb2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]   REM_ONE    = (AW + 1)'(1);
    localparam logic [CW:0]   FIFO_LIMIT = (CW + 1)'(FIFO_DEPTH);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end

    state_t                state;
    state_t                state_nxt;
    logic [AW-1:0]         cur_addr;
    logic [AW:0]           remaining;
    logic [RD_LATENCY-1:0] rd_vld_p;
    logic [RD_LATENCY-1:0] rd_last_p;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [RAM_WIDTH:0]    fifo_rd_data;
    logic                  fifo_valid;
    logic                  credit;
    logic                  issue;
    logic                  pop;
    logic                  last_pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(rd_vld_p[i]);
        end
    end

    // A pop in this cycle is deliberately not credited; registered count only.
    assign credit   = ({1'b0, fifo_count} + {1'b0, inflight}) < FIFO_LIMIT;
    assign pop      = fifo_valid && strm.m_tready;
    assign last_pop = pop && fifo_rd_data[RAM_WIDTH];

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (length == '0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (remaining == REM_ONE) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            cur_addr  <= base_addr;
            remaining <= length;
        end else if (issue) begin
            cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Read-latency tracking: stage RD_LATENCY-1 lines up with doutb.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            rd_vld_p  <= '0;
            rd_last_p <= '0;
        end else begin
            rd_vld_p[0]  <= issue;
            rd_last_p[0] <= issue && (remaining == REM_ONE);
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_p[i]  <= rd_vld_p[i-1];
                rd_last_p[i] <= rd_last_p[i-1];
            end
        end
    end

    line_rd_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clka),
        .rstn    (rstn),
        .wr_en   (rd_vld_p[RD_LATENCY-1]),
        .wr_data ({rd_last_p[RD_LATENCY-1], doutb}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign addrb         = cur_addr;
    assign enb           = issue;
    assign regceb        = 1'b1;
    assign rstb          = 1'b0;
    assign busy          = (state == ISSUE) || (state == DRAIN);
    assign done          = (state == FINISH);
    assign strm.m_tdata  = fifo_rd_data[RAM_WIDTH-1:0];
    assign strm.m_tvalid = fifo_valid;
    assign strm.m_tlast  = fifo_rd_data[RAM_WIDTH];

endmodule

// File: tb/tb_dpram_line_reader.sv
// Bench for dpram_line_reader: RAM models at latency 2 and 1, random stream
// backpressure, and an address/data reference computed from base+k mod depth.
module tb_dpram_line_reader;

    localparam int W     = 64;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int FD    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          start, start_b;
    logic [AW-1:0] base_addr, base_b;
    logic [AW:0]   length, length_b;
    logic          busy, done, enb, regceb, rstb;
    logic          busy_b, done_b, enb_b, regceb_b, rstb_b;
    logic [AW-1:0] addrb, addrb_b;
    logic [W-1:0]  doutb, doutb_b, ram_q1;

    dpram_line_reader_if #(.RAM_WIDTH(W)) sa ();
    dpram_line_reader_if #(.RAM_WIDTH(W)) sb ();

    dpram_line_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RD_LATENCY(2), .FIFO_DEPTH(FD)) u_dut (
        .clka(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .addrb(addrb), .enb(enb), .regceb(regceb), .rstb(rstb),
        .doutb(doutb), .strm(sa)
    );

    dpram_line_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RD_LATENCY(1), .FIFO_DEPTH(FD)) u_dut_b (
        .clka(clk), .rstn(rstn), .start(start_b), .base_addr(base_b), .length(length_b),
        .busy(busy_b), .done(done_b), .addrb(addrb_b), .enb(enb_b), .regceb(regceb_b), .rstb(rstb_b),
        .doutb(doutb_b), .strm(sb)
    );

    // RAM models: shared contents, two-register and one-register read paths.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (enb) ram_q1 <= mem[addrb];
        doutb <= ram_q1;
    end
    always @(posedge clk) begin
        if (enb_b) doutb_b <= mem[addrb_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int t0, t0b;

    logic [W-1:0]  data_q [$];
    logic          last_q [$];
    int            vcyc_q [$];
    logic [AW-1:0] addr_q [$];
    int  first_enb, first_vld, done_cnt, done_cyc, vld_cnt, issued, popped, max_out, stall_err;
    bit  mon_en = 1'b0;
    bit  prev_stall;
    logic [W-1:0] prev_data;
    logic prev_last;

    logic [W-1:0] qb [$];
    logic         lb [$];
    int first_vld_b = -1, first_enb_b = -1, done_cnt_b = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (enb) begin
                addr_q.push_back(addrb);
                issued++;
                if (first_enb < 0) first_enb = cyc;
            end
            if (sa.m_tvalid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
            end
            if (prev_stall && (!sa.m_tvalid || sa.m_tdata !== prev_data || sa.m_tlast !== prev_last))
                stall_err++;
            if (sa.m_tvalid && sa.m_tready) begin
                data_q.push_back(sa.m_tdata);
                last_q.push_back(sa.m_tlast);
                vcyc_q.push_back(cyc);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_stall = sa.m_tvalid && !sa.m_tready;
            prev_data  = sa.m_tdata;
            prev_last  = sa.m_tlast;
        end
    end

    always @(negedge clk) begin
        if (enb_b && first_enb_b < 0) first_enb_b = cyc;
        if (sb.m_tvalid && first_vld_b < 0) first_vld_b = cyc;
        if (sb.m_tvalid && sb.m_tready) begin
            qb.push_back(sb.m_tdata);
            lb.push_back(sb.m_tlast);
        end
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        data_q.delete(); last_q.delete(); vcyc_q.delete(); addr_q.delete();
        first_enb = -1; first_vld = -1; done_cnt = 0; done_cyc = -1; vld_cnt = 0;
        issued = 0; popped = 0; max_out = 0; stall_err = 0; prev_stall = 1'b0;
    endtask

    function automatic logic ready_for(input int mode, input int rel);
        if (mode == 1) return !(rel >= 5 && rel <= 20);
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    task automatic run_cmd(input int base, input int len, input int rmode);
        clear_logs();
        @(posedge clk); #1;
        base_addr   = AW'(base);
        length      = (AW + 1)'(len);
        start       = 1'b1;
        t0          = cyc;
        sa.m_tready = ready_for(rmode, 0);
        mon_en      = 1'b1;
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            sa.m_tready = ready_for(rmode, cyc - t0);
        end
        check("done_within_budget", W'(done_cnt != 0), W'(1));
        sa.m_tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input int base, input int len);
        check("word_count", W'(data_q.size()), W'(len));
        check("issue_count", W'(addr_q.size()), W'(len));
        for (int k = 0; k < len; k++) begin
            if (k < addr_q.size()) check("addrb_seq", W'(addr_q[k]), W'((base + k) % DEPTH));
            if (k < data_q.size()) begin
                check("tdata", data_q[k], mem[(base + k) % DEPTH]);
                check("tlast", W'(last_q[k]), W'(k == len - 1));
            end
        end
        check("done_once", W'(done_cnt), W'(1));
        if (data_q.size() > 0) check("done_after_last", W'(done_cyc), W'(vcyc_q[data_q.size() - 1] + 1));
        check("hold_while_stalled", W'(stall_err), W'(0));
        check("outstanding_bound", W'(max_out <= FD), W'(1));
        check("busy_low_after", W'(busy), W'(0));
    endtask

    initial begin
        int b, l;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) mem[i] = W'(i);
        rstn = 1'b0; start = 1'b0; start_b = 1'b0;
        base_addr = '0; length = '0; base_b = '0; length_b = '0;
        sa.m_tready = 1'b1; sb.m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_enb", W'(enb), W'(0));
        check("rst_addrb", W'(addrb), W'(0));
        check("rst_tvalid", W'(sa.m_tvalid), W'(0));
        check("rst_tlast", W'(sa.m_tlast), W'(0));
        check("rst_tdata", sa.m_tdata, W'(0));
        check("rst_regceb", W'(regceb), W'(1));
        check("rst_rstb", W'(rstb), W'(0));
        rstn = 1'b1;

        run_cmd(0, 8, 0);
        check_stream(0, 8);
        check("first_enb_lat", W'(first_enb - t0), W'(1));
        check("first_vld_lat", W'(first_vld - t0), W'(4));
        if (vcyc_q.size() == 8) check("back_to_back", W'(vcyc_q[7] - vcyc_q[0]), W'(7));

        run_cmd(1020, 8, 0);
        check_stream(1020, 8);

        b = $urandom_range(0, DEPTH - 1);
        run_cmd(b, 16, 1);
        check_stream(b, 16);
        check("stall_fills_credit", W'(max_out), W'(FD));

        run_cmd(300, 1, 0);
        check_stream(300, 1);
        run_cmd(400, 0, 0);
        check("len0_no_valid", W'(vld_cnt), W'(0));
        check("len0_no_enb", W'(issued), W'(0));
        check("len0_done_once", W'(done_cnt), W'(1));
        check("len0_done_cycle", W'(done_cyc - t0), W'(1));

        for (int n = 0; n < 6; n++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            run_cmd(b, l, 2);
            check_stream(b, l);
        end

        // Reset in the middle of a 32-word command.
        clear_logs();
        @(posedge clk); #1;
        base_addr = AW'(50); length = (AW + 1)'(32); start = 1'b1; t0 = cyc;
        sa.m_tready = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_had_words", W'(data_q.size() > 0), W'(1));
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_enb", W'(enb), W'(0));
        check("midrst_addrb", W'(addrb), W'(0));
        check("midrst_tvalid", W'(sa.m_tvalid), W'(0));
        check("midrst_tlast", W'(sa.m_tlast), W'(0));
        check("midrst_tdata", sa.m_tdata, W'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", W'(done_cnt), W'(0));
        b = $urandom_range(0, DEPTH - 1);
        run_cmd(b, 20, 2);
        check_stream(b, 20);

        // Latency-1 instance, with a second start while busy.
        qb.delete(); lb.delete();
        first_vld_b = -1; first_enb_b = -1; done_cnt_b = 0;
        @(posedge clk); #1;
        base_b = AW'(100); length_b = (AW + 1)'(4); start_b = 1'b1; t0b = cyc;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(posedge clk); #1;
        base_b = AW'(500); length_b = (AW + 1)'(3); start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("lat1_first_enb", W'(first_enb_b - t0b), W'(1));
        check("lat1_first_vld", W'(first_vld_b - t0b), W'(3));
        check("lat1_word_count", W'(qb.size()), W'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < qb.size()) begin
                check("lat1_tdata", qb[k], mem[100 + k]);
                check("lat1_tlast", W'(lb[k]), W'(k == 3));
            end
        end
        check("lat1_done_once", W'(done_cnt_b), W'(1));
        check("lat1_busy_low", W'(busy_b), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
